// File: rtl/input_port.sv
// input_port: debounced, handshaked push-button / switch-bank input peripheral.
// Optional feature macro: INPUT_PORT_OVERRUN_EN
//   defined   -> a press while data is still unconsumed keeps the old data and
//                raises a sticky overrun flag (cleared by rd_ack or reset).
//   undefined -> a press while data is unconsumed overwrites the data (latest
//                wins) and overrun is tied low.
module input_port #(
   parameter int DATA_W          = 8,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              btn_in,
   input  logic [DATA_W-1:0] sw_in,
   input  logic              rd_ack,
   output logic              ready_out,
   output logic [DATA_W-1:0] data_out,
   output logic              overrun
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      READY = 1'b1
   } state_t;

   // Two-flop synchronisers; *_sync_r is the synchronised level used everywhere else.
   logic              btn_meta_r;
   logic              btn_sync_r;
   logic [DATA_W-1:0] sw_meta_r;
   logic [DATA_W-1:0] sw_sync_r;

   // Debouncer state.
   logic              db_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              db_next_s;
   logic [CNT_W-1:0]  cnt_next_s;
   logic              press_s;

   // Handshake FSM and registered outputs.
   state_t            state_r;
   state_t            state_next_s;
   logic              ready_r;
   logic [DATA_W-1:0] data_r;
   logic [DATA_W-1:0] data_next_s;
`ifdef INPUT_PORT_OVERRUN_EN
   logic              overrun_r;
   logic              overrun_next_s;
`endif

   // Bring the raw button and switch pins into the clk domain.
   always_ff @(posedge clk) begin
      if (reset) begin
         btn_meta_r <= 1'b0;
         btn_sync_r <= 1'b0;
         sw_meta_r  <= '0;
         sw_sync_r  <= '0;
      end else begin
         btn_meta_r <= btn_in;
         btn_sync_r <= btn_meta_r;
         sw_meta_r  <= sw_in;
         sw_sync_r  <= sw_meta_r;
      end
   end

   // Debounce: accept a new level only after it differs from db_r for DEBOUNCE_CYCLES cycles.
   always_comb begin
      db_next_s  = db_r;
      cnt_next_s = '0;
      press_s    = 1'b0;
      if (btn_sync_r == db_r) begin
         cnt_next_s = '0;
      end else if (cnt_r == CNT_MAX) begin
         db_next_s  = btn_sync_r;
         cnt_next_s = '0;
         // Only the 0->1 acceptance is a press; releases produce no event.
         press_s    = btn_sync_r;
      end else begin
         cnt_next_s = cnt_r + CNT_W'(1);
      end
   end

   // Debouncer level and stability counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         db_r  <= 1'b0;
         cnt_r <= '0;
      end else begin
         db_r  <= db_next_s;
         cnt_r <= cnt_next_s;
      end
   end

   // Handshake next-state: capture on press, release on rd_ack, resolve press-while-full.
   always_comb begin
      state_next_s   = state_r;
      data_next_s    = data_r;
`ifdef INPUT_PORT_OVERRUN_EN
      overrun_next_s = overrun_r;
`endif
      case (state_r)
         IDLE: begin
            if (press_s) begin
               data_next_s  = sw_sync_r;
               state_next_s = READY;
            end else begin
               state_next_s = IDLE;
            end
         end
         READY: begin
            if (rd_ack && press_s) begin
               // CPU consumed the old value in the same cycle: new value is a fresh capture.
               data_next_s    = sw_sync_r;
               state_next_s   = READY;
`ifdef INPUT_PORT_OVERRUN_EN
               overrun_next_s = 1'b0;
`endif
            end else if (rd_ack) begin
               state_next_s   = IDLE;
`ifdef INPUT_PORT_OVERRUN_EN
               overrun_next_s = 1'b0;
`endif
            end else if (press_s) begin
               state_next_s   = READY;
`ifdef INPUT_PORT_OVERRUN_EN
               overrun_next_s = 1'b1;
`else
               data_next_s    = sw_sync_r;
`endif
            end else begin
               state_next_s = READY;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // FSM state and registered output stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         ready_r   <= 1'b0;
         data_r    <= '0;
`ifdef INPUT_PORT_OVERRUN_EN
         overrun_r <= 1'b0;
`endif
      end else begin
         state_r   <= state_next_s;
         ready_r   <= (state_next_s == READY);
         data_r    <= data_next_s;
`ifdef INPUT_PORT_OVERRUN_EN
         overrun_r <= overrun_next_s;
`endif
      end
   end

   assign ready_out = ready_r;
   assign data_out  = data_r;
`ifdef INPUT_PORT_OVERRUN_EN
   assign overrun   = overrun_r;
`else
   assign overrun   = 1'b0;
`endif

endmodule

// File: doc/input_port.md
# input_port

Debounced, handshaked input peripheral sitting between the board push-button/switches and the CPU's `ready_in`/`sw` inputs. Synchronises the raw button and switch bank, debounces the button, and on each clean press captures the switch value. It then holds `ready_out` high with stable data until the CPU acknowledges with `rd_ack`. It runs on the divided CPU `clk` domain and replaces the direct raw-pin connection at the top level.

## Interface
- `DATA_W`, 8, width of switch bank and captured data.
- `DEBOUNCE_CYCLES`, 16, consecutive stable cycles required to accept a button level change; must be ≥ 2.
- `clk`  input  1  CPU clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `btn_in`  input  1  raw asynchronous push-button, active-high.
- `sw_in`  input  DATA_W  raw asynchronous switch bank.
- `rd_ack`  input  1  single-cycle pulse from CPU: data consumed.
- `ready_out`  output  1  data valid; drives CPU `ready_in`.
- `data_out`  output  DATA_W  captured switch value; drives CPU `sw`.
- `overrun`  output  1  sticky: press lost while data unconsumed.

## Operation
- Synchroniser: `btn_in` and every `sw_in` bit pass through two flops → `btn_s`, `sw_s`. Switches are not debounced.
- Debouncer: registered level `db` plus counter of width clog2(DEBOUNCE_CYCLES).
  - `btn_s == db`: counter ← 0.
  - `btn_s != db`, counter < DEBOUNCE_CYCLES-1: counter increments.
  - `btn_s != db`, counter == DEBOUNCE_CYCLES-1: `db` ← `btn_s`, counter ← 0.
  - Press event = the cycle in which `db` is updated 0→1. Release events generate nothing.
- FSM states IDLE, READY:
  - IDLE: `ready_out`=0. On press: `data_out` ← `sw_s`, → READY. `rd_ack` ignored.
  - READY: `ready_out`=1, `data_out` frozen.
    - `rd_ack` alone → IDLE.
    - `rd_ack` and press in the same cycle → capture new `sw_s`, stay READY, no overrun.
    - Press without `rd_ack` → see Configuration.
- Reset clears synchroniser flops, `db`, counter, `data_out`, `overrun`, and forces IDLE, including mid-debounce or mid-READY.

## Timing
- Reset values: `ready_out`=0, `data_out`=0, `overrun`=0.
- Latency: with `btn_in` held high from before edge 0, `btn_s`=1 after edge 2. `db` and `ready_out` rise together after edge 2+DEBOUNCE_CYCLES. `data_out` = `sw_s` sampled at that same edge, i.e. `sw_in` as of 2 edges earlier.
- Pulses shorter than DEBOUNCE_CYCLES cycles at `btn_s` never produce a press. Any single mismatch-free cycle restarts the count.
- `ready_out` falls on the edge that samples `rd_ack`=1. The earliest next assertion is from a new press.
- `data_out` changes only on the edge where a press is accepted.

## Configuration
- `INPUT_PORT_OVERRUN_EN` defined: press in READY without `rd_ack` keeps old `data_out` and sets `overrun`=1 on that edge. `overrun` stays 1 until the edge sampling `rd_ack`=1, or until reset.
- Undefined: press in READY overwrites `data_out` with `sw_s` (latest wins), `ready_out` stays 1, and `overrun` is tied 0.

## Test plan
- Reset held 3 cycles with `btn_in`=1, `sw_in`=0xFF → `ready_out`=0, `data_out`=0x00, `overrun`=0 throughout.
- DEBOUNCE_CYCLES=4, `sw_in`=0xA5, `btn_in` 0→1 before edge 0 and held → `ready_out` rises after edge 6 with `data_out`=0xA5. `rd_ack` pulse → `ready_out`=0 the next cycle, `data_out` still 0xA5.
- DEBOUNCE_CYCLES=4, `btn_in` high for 3 cycles then low, repeated 5 times → `ready_out` never asserts.
- After capturing 0xA5, release, then press again with `sw_in`=0x3C and no ack:
  - macro defined → `data_out`=0xA5, `overrun`=1; ack → `overrun`=0, `ready_out`=0.
  - macro undefined → `data_out`=0x3C, `overrun`=0.
- In READY, `rd_ack` asserted in the exact press-accept cycle with `sw_in`=0x5A → `ready_out` stays 1, `data_out`=0x5A, `overrun`=0.
- `reset` pulsed while debounce counter = 2, `btn_in` held high → counter restarts. `ready_out` rises DEBOUNCE_CYCLES+2 edges after reset deasserts.
